// File: rtl/flash_read_arbiter_if.sv
// Handshake bundle between the two flash requesters, the arbiter and the flash byte-read controller.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface flash_read_arbiter_if #(
   parameter int ADDR_W = 11
);
   logic              req0Enable;
   logic [ADDR_W-1:0] req0Addr;
   logic              req0DataReady;
   logic [7:0]        req0Byte;
   logic              req1Enable;
   logic [ADDR_W-1:0] req1Addr;
   logic              req1DataReady;
   logic [7:0]        req1Byte;
   logic              flashEnable;
   logic [ADDR_W-1:0] flashAddr;
   logic              flashDataReady;
   logic [7:0]        flashByte;
   logic              grantId;
   logic              busy;
   logic              timeoutErr;

   modport slave (
      input  req0Enable, req0Addr, req1Enable, req1Addr, flashDataReady, flashByte,
      output req0DataReady, req0Byte, req1DataReady, req1Byte,
      output flashEnable, flashAddr, grantId, busy, timeoutErr
   );

   modport master (
      output req0Enable, req0Addr, req1Enable, req1Addr, flashDataReady, flashByte,
      input  req0DataReady, req0Byte, req1DataReady, req1Byte,
      input  flashEnable, flashAddr, grantId, busy, timeoutErr
   );
endinterface

// File: rtl/flash_read_arbiter.sv
// Round-robin sharing of one flash byte-read controller between the cpu fetch (0) and the font loader (1),
// one whole flash transaction per grant, with a sticky watchdog against a hung flash.
module flash_read_arbiter #(
   parameter int ADDR_W  = 11,
   parameter int TIMEOUT = 65535
) (
   input logic               clk,
   input logic               reset,
   flash_read_arbiter_if.slave bus
);
   localparam int WDOG_W = $clog2(TIMEOUT + 1);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_START,
      WAIT_DONE,
      DELIVER,
      RELEASE
   } state_t;

   state_t            state_q, state_d;
   logic              grant_q, grant_d;
   logic              last_grant_q, last_grant_d;
   logic              flash_en_q, flash_en_d;
   logic [ADDR_W-1:0] flash_addr_q, flash_addr_d;
   logic [1:0]        rdy_q, rdy_d;
   logic [1:0][7:0]   byte_q, byte_d;
   logic              busy_q, busy_d;
   logic              timeout_err_q, timeout_err_d;
   logic [WDOG_W-1:0] wdog_q, wdog_d;

   logic [1:0]        req_en;
   logic [ADDR_W-1:0] req_addr [2];
   logic              winner;
   logic              wdog_fire;

   assign req_en      = {bus.req1Enable, bus.req0Enable};
   assign req_addr[0] = bus.req0Addr;
   assign req_addr[1] = bus.req1Addr;

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_grant_d  = last_grant_q;
      flash_en_d    = flash_en_q;
      flash_addr_d  = flash_addr_q;
      rdy_d         = rdy_q;
      byte_d        = byte_q;
      timeout_err_d = timeout_err_q;
      wdog_d        = wdog_q;
      winner        = 1'b0;
      wdog_fire     = 1'b0;

      // A requester reads not-ready as soon as its enable is seen, unless it is the one being served.
      for (int n = 0; n < 2; n++) begin
         if (!req_en[n]) begin
            rdy_d[n] = 1'b1;
         end else if (state_q == DELIVER && grant_q == 1'(n)) begin
            rdy_d[n] = 1'b1;
         end else begin
            rdy_d[n] = 1'b0;
         end
      end

      case (state_q)
         IDLE: begin
            if (|req_en) begin
               winner       = (&req_en) ? ~last_grant_q : req_en[1];
               grant_d      = winner;
               last_grant_d = winner;
               flash_addr_d = req_addr[winner];
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            flash_en_d = 1'b1;
            wdog_d     = '0;
            state_d    = WAIT_START;
         end
         WAIT_START: begin
            wdog_d    = wdog_q + 1'b1;
            wdog_fire = (wdog_q == WDOG_LAST);
            if (!bus.flashDataReady) begin
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            wdog_d = wdog_q + 1'b1;
            if (bus.flashDataReady) begin
               if (req_en[grant_q]) begin
                  byte_d[grant_q] = bus.flashByte;
                  rdy_d[grant_q]  = 1'b1;
                  state_d         = DELIVER;
               end else begin
                  state_d = RELEASE;
               end
            end else begin
               wdog_fire = (wdog_q == WDOG_LAST);
            end
         end
         DELIVER: begin
            if (!req_en[grant_q]) begin
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            flash_en_d = 1'b0;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A hung flash still completes the transaction, with a poison byte and a sticky error.
      if (wdog_fire) begin
         timeout_err_d   = 1'b1;
         byte_d[grant_q] = 8'hFF;
         if (req_en[grant_q]) begin
            rdy_d[grant_q] = 1'b1;
            state_d        = DELIVER;
         end else begin
            state_d = RELEASE;
         end
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         grant_q       <= 1'b0;
         last_grant_q  <= 1'b1;
         flash_en_q    <= 1'b0;
         flash_addr_q  <= '0;
         rdy_q         <= 2'b11;
         byte_q        <= '0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
         wdog_q        <= '0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         last_grant_q  <= last_grant_d;
         flash_en_q    <= flash_en_d;
         flash_addr_q  <= flash_addr_d;
         rdy_q         <= rdy_d;
         byte_q        <= byte_d;
         busy_q        <= busy_d;
         timeout_err_q <= timeout_err_d;
         wdog_q        <= wdog_d;
      end
   end

   assign bus.flashEnable   = flash_en_q;
   assign bus.flashAddr     = flash_addr_q;
   assign bus.req0DataReady = rdy_q[0];
   assign bus.req1DataReady = rdy_q[1];
   assign bus.req0Byte      = byte_q[0];
   assign bus.req1Byte      = byte_q[1];
   assign bus.grantId       = grant_q;
   assign bus.busy          = busy_q;
   assign bus.timeoutErr    = timeout_err_q;
endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed bench for flash_read_arbiter: a negedge-driven flash model with fixed latency or hang,
// and hand-computed expectations for grants, bytes, handshakes, watchdog and reset.
module tb_flash_read_arbiter;
   localparam int ADDR_W        = 11;
   localparam int TIMEOUT       = 20;
   localparam int FLASH_LATENCY = 10;

   logic clk;
   logic reset;
   bit   flashHang;
   bit   flashActive;
   int   flashCount;
   int   assertCount;
   int   failCount;

   flash_read_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

   flash_read_arbiter #(
      .ADDR_W (ADDR_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Flash contents: address 5 holds A7, every other byte is the low address bits xor C3.
   function automatic logic [7:0] flashMem(input logic [ADDR_W-1:0] addr);
      logic [7:0] low;
      low = addr[7:0];
      return (addr == 11'h005) ? 8'hA7 : (low ^ 8'hC3);
   endfunction

   // Flash controller model: goes busy the half-cycle after enable rises, done FLASH_LATENCY cycles later.
   initial begin
      bus.flashDataReady = 1'b1;
      bus.flashByte      = 8'h00;
      flashActive        = 1'b0;
      flashCount         = 0;
      forever begin
         @(negedge clk);
         if (reset || !bus.flashEnable) begin
            bus.flashDataReady = 1'b1;
            flashActive        = 1'b0;
         end else if (!flashActive) begin
            flashActive        = 1'b1;
            bus.flashDataReady = 1'b0;
            flashCount         = FLASH_LATENCY;
         end else if (!flashHang && flashCount > 0) begin
            flashCount--;
            if (flashCount == 0) begin
               bus.flashDataReady = 1'b1;
               bus.flashByte      = flashMem(bus.flashAddr);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int who, input logic en, input logic [ADDR_W-1:0] addr);
      if (who == 0) begin
         bus.req0Enable = en;
         bus.req0Addr   = addr;
      end else begin
         bus.req1Enable = en;
         bus.req1Addr   = addr;
      end
   endtask

   task automatic waitReady(input int who, input int bound, input string tag);
      int n;
      logic rdy;
      n = 0;
      do begin
         tick();
         n++;
         rdy = (who == 0) ? bus.req0DataReady : bus.req1DataReady;
      end while (!rdy && n < bound);
      checkOutput(tag, rdy, 1);
   endtask

   task automatic waitIdle(input int bound, input string tag);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (bus.busy && n < bound);
      checkOutput(tag, bus.busy, 0);
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      flashHang   = 1'b0;
      reset       = 1'b1;
      applyStimulus(0, 1'b0, '0);
      applyStimulus(1, 1'b0, '0);
      tick();
      tick();

      $display("[TB] reset values");
      checkOutput("rst_flashEnable", bus.flashEnable, 0);
      checkOutput("rst_flashAddr", bus.flashAddr, 0);
      checkOutput("rst_rdy0", bus.req0DataReady, 1);
      checkOutput("rst_rdy1", bus.req1DataReady, 1);
      checkOutput("rst_byte0", bus.req0Byte, 0);
      checkOutput("rst_byte1", bus.req1Byte, 0);
      checkOutput("rst_grant", bus.grantId, 0);
      checkOutput("rst_busy", bus.busy, 0);
      checkOutput("rst_timeout", bus.timeoutErr, 0);
      reset = 1'b0;
      tick();

      $display("[TB] single request");
      applyStimulus(0, 1'b1, 11'h005);
      tick();
      checkOutput("single_rdy0_low", bus.req0DataReady, 0);
      checkOutput("single_en_not_yet", bus.flashEnable, 0);
      checkOutput("single_busy", bus.busy, 1);
      checkOutput("single_grant", bus.grantId, 0);
      tick();
      checkOutput("single_en_rise", bus.flashEnable, 1);
      checkOutput("single_addr", bus.flashAddr, 11'h005);
      waitReady(0, 40, "single_ready");
      checkOutput("single_byte", bus.req0Byte, 8'hA7);
      checkOutput("single_en_held", bus.flashEnable, 1);
      applyStimulus(0, 1'b0, 11'h005);
      tick();
      tick();
      checkOutput("single_en_fall", bus.flashEnable, 0);
      checkOutput("single_idle", bus.busy, 0);
      checkOutput("single_rdy0_idle", bus.req0DataReady, 1);

      $display("[TB] simultaneous requests");
      reset = 1'b1;
      tick();
      reset = 1'b0;
      applyStimulus(0, 1'b1, 11'h010);
      applyStimulus(1, 1'b1, 11'h020);
      tick();
      checkOutput("sim_rdy0_low", bus.req0DataReady, 0);
      checkOutput("sim_rdy1_low", bus.req1DataReady, 0);
      checkOutput("sim_first_grant", bus.grantId, 0);
      waitReady(0, 40, "sim_ready0");
      checkOutput("sim_byte0", bus.req0Byte, 8'hD3);
      checkOutput("sim_rdy1_waiting", bus.req1DataReady, 0);
      applyStimulus(0, 1'b0, 11'h010);
      waitReady(1, 60, "sim_ready1");
      checkOutput("sim_second_grant", bus.grantId, 1);
      checkOutput("sim_addr1", bus.flashAddr, 11'h020);
      checkOutput("sim_byte1", bus.req1Byte, 8'hE3);
      applyStimulus(1, 1'b0, 11'h020);
      waitIdle(10, "sim_idle");

      $display("[TB] round-robin fairness");
      applyStimulus(0, 1'b1, 11'h030);
      applyStimulus(1, 1'b1, 11'h041);
      for (int k = 0; k < 6; k++) begin
         int n;
         int who;
         n   = 0;
         who = k % 2;
         do begin
            tick();
            n++;
         end while (!((bus.req0Enable && bus.req0DataReady) || (bus.req1Enable && bus.req1DataReady)) && n < 60);
         checkOutput("rr_grant", bus.grantId, who);
         checkOutput("rr_ready", (who == 0) ? bus.req0DataReady : bus.req1DataReady, 1);
         checkOutput("rr_byte", (who == 0) ? bus.req0Byte : bus.req1Byte, (who == 0) ? 8'hF3 : 8'h82);
         applyStimulus(who, 1'b0, (who == 0) ? 11'h030 : 11'h041);
         tick();
         if (k < 5) begin
            applyStimulus(who, 1'b1, (who == 0) ? 11'h030 : 11'h041);
         end
      end
      applyStimulus(0, 1'b0, 11'h030);
      waitIdle(10, "rr_idle");

      $display("[TB] abort");
      applyStimulus(1, 1'b1, 11'h0FF);
      tick();
      tick();
      tick();
      checkOutput("abort_busy", bus.busy, 1);
      checkOutput("abort_en", bus.flashEnable, 1);
      applyStimulus(1, 1'b0, 11'h0FF);
      applyStimulus(0, 1'b1, 11'h0AA);
      waitIdle(40, "abort_release");
      checkOutput("abort_byte1_kept", bus.req1Byte, 8'h82);
      checkOutput("abort_rdy1_idle", bus.req1DataReady, 1);
      checkOutput("abort_en_low", bus.flashEnable, 0);
      tick();
      checkOutput("abort_next_busy", bus.busy, 1);
      checkOutput("abort_next_grant", bus.grantId, 0);
      checkOutput("abort_next_addr", bus.flashAddr, 11'h0AA);
      waitReady(0, 40, "abort_ready0");
      checkOutput("abort_byte0", bus.req0Byte, 8'h69);
      applyStimulus(0, 1'b0, 11'h0AA);
      waitIdle(10, "abort_idle");

      $display("[TB] watchdog timeout");
      flashHang = 1'b1;
      applyStimulus(0, 1'b1, 11'h007);
      repeat (21) tick();
      checkOutput("to_not_yet", bus.timeoutErr, 0);
      checkOutput("to_rdy0_low", bus.req0DataReady, 0);
      tick();
      checkOutput("to_flag", bus.timeoutErr, 1);
      checkOutput("to_rdy0", bus.req0DataReady, 1);
      checkOutput("to_byte", bus.req0Byte, 8'hFF);
      applyStimulus(0, 1'b0, 11'h007);
      waitIdle(10, "to_idle");
      flashHang = 1'b0;
      applyStimulus(1, 1'b1, 11'h012);
      waitReady(1, 40, "to_good_ready");
      checkOutput("to_good_byte", bus.req1Byte, 8'hD1);
      checkOutput("to_sticky", bus.timeoutErr, 1);
      applyStimulus(1, 1'b0, 11'h012);
      waitIdle(10, "to_good_idle");

      $display("[TB] reset mid-transaction");
      applyStimulus(0, 1'b1, 11'h020);
      tick();
      tick();
      tick();
      checkOutput("mid_en_before", bus.flashEnable, 1);
      reset = 1'b1;
      tick();
      checkOutput("mid_en", bus.flashEnable, 0);
      checkOutput("mid_busy", bus.busy, 0);
      checkOutput("mid_rdy0", bus.req0DataReady, 1);
      checkOutput("mid_rdy1", bus.req1DataReady, 1);
      checkOutput("mid_timeout_clr", bus.timeoutErr, 0);
      applyStimulus(0, 1'b0, 11'h020);
      reset = 1'b0;
      applyStimulus(1, 1'b1, 11'h033);
      tick();
      checkOutput("mid_rdy1_low", bus.req1DataReady, 0);
      checkOutput("mid_grant", bus.grantId, 1);
      tick();
      checkOutput("mid_en_rise", bus.flashEnable, 1);
      checkOutput("mid_addr", bus.flashAddr, 11'h033);
      waitReady(1, 40, "mid_ready1");
      checkOutput("mid_byte1", bus.req1Byte, 8'hF0);
      applyStimulus(1, 1'b0, 11'h033);
      waitIdle(10, "mid_idle");

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end
endmodule

// File: doc/flash_read_arbiter.md
Name: flash_read_arbiter

Overview:
- Shares the single flash byte-read controller between two requesters: requester 0 is the cpu instruction/param fetch, requester 1 is a text/font loader.
- Each requester sees the same enable/addr/dataReady handshake that the flash controller exposes. The block is a transparent drop-in on either side.
- Grants are round-robin, one complete flash transaction at a time. A watchdog guards against a hung flash.

Parameters:
- ADDR_W, 11, flash byte address width.
- TIMEOUT, 65535, max cycles spent waiting on the flash for one transaction (WAIT_START + WAIT_DONE).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- req0Enable  in  1  requester 0 read request; held high until byte taken
- req0Addr  in  ADDR_W  requester 0 address, stable while req0Enable high
- req0DataReady  out  1  requester 0 ready/data-valid
- req0Byte  out  8  requester 0 read data
- req1Enable, req1Addr, req1DataReady, req1Byte: same as requester 0, for requester 1
- flashEnable  out  1  to flash controller
- flashAddr  out  ADDR_W  to flash controller
- flashDataReady  in  1  from flash controller: high when idle or done, low while busy
- flashByte  in  8  from flash controller
- grantId  out  1  requester currently owning the flash; valid while busy=1
- busy  out  1  high in any state other than IDLE
- timeoutErr  out  1  sticky watchdog flag

Behaviour:
- All outputs are registered.
- Reset values: flashEnable=0, flashAddr=0, reqNDataReady=1, reqNByte=0, grantId=0, busy=0, timeoutErr=0, lastGrant=1 (requester 0 wins the first tie), state=IDLE, watchdog=0.
- Requester handshake (per requester N):
  - Idle: reqNDataReady=1.
  - The cycle after reqNEnable is sampled high while N is not in DELIVER, reqNDataReady goes 0. The requester can therefore see its not-ready phase even while waiting for a grant.
  - reqNDataReady returns to 1, with reqNByte valid, only in DELIVER for N.
  - reqNDataReady stays 1 until the requester drops reqNEnable. It then remains 1, which is the idle value.
- States:
  - IDLE:
    - If either enable is high, pick a winner. If both are high, the winner is ~lastGrant; otherwise the single requester.
    - Latch grantId, lastGrant, and flashAddr=winner's addr. Go to ISSUE.
  - ISSUE: flashEnable<=1, watchdog<=0, go to WAIT_START.
  - WAIT_START: when flashDataReady==0, go to WAIT_DONE.
  - WAIT_DONE:
    - When flashDataReady==1, capture flashByte.
    - If the granted requester's enable is still high: reqByte<=flashByte, reqDataReady<=1, go to DELIVER.
    - Otherwise (requester aborted): discard the byte, go to RELEASE.
  - DELIVER: when the granted requester's enable==0, go to RELEASE.
  - RELEASE: flashEnable<=0, go to IDLE.
- Timing:
  - Arbitration occupies one cycle, so flashEnable rises 2 cycles after a request is sampled in IDLE.
  - The next grant can begin no earlier than 1 cycle after RELEASE.
- Watchdog:
  - Counts every cycle in WAIT_START and WAIT_DONE.
  - On reaching TIMEOUT: timeoutErr<=1 (sticky until reset), reqByte<=8'hFF. Then, if the requester's enable is still high, DELIVER; else RELEASE.
- Request changes:
  - A requester that drops enable before being granted is simply not granted. No flash activity results.
  - Address changes after grant are ignored; flashAddr is latched.
- Fairness: a requester that re-requests immediately after RELEASE loses to a waiting other requester.
- Reset mid-transaction: everything returns to reset values the next cycle, including flashEnable=0. The flash controller must tolerate an enable drop at any time.

Test Plan:
- Single request:
  - Stimulus: req0 asks addr 11'h005; the flash model returns 8'hA7 after 10 cycles.
  - Required response: flashEnable rises 2 cycles after the request and flashAddr=5. req0DataReady goes 0, then returns to 1 with req0Byte=A7. flashEnable falls the cycle after req0Enable drops.
- Simultaneous requests:
  - Stimulus: req0 and req1 are raised on the same cycle after reset.
  - Required response: req0 is served first. req1DataReady stays 0 until its own grant, and req1 is served next with its own address and byte.
- Round-robin fairness:
  - Stimulus: both requesters hold continuous back-to-back requests for 6 transactions.
  - Required response: grantId sequence is 0,1,0,1,0,1.
- Abort:
  - Stimulus: req1 drops enable while in WAIT_DONE; the flash returns 8'h3C.
  - Required response: req1Byte is unchanged, the state goes through RELEASE to IDLE, and a pending req0 is granted next.
- Timeout:
  - Stimulus: TIMEOUT=20; the flash model never raises flashDataReady.
  - Required response: after 20 wait cycles, timeoutErr=1 and req0Byte=FF with req0DataReady=1. timeoutErr stays 1 across later good transactions.
- Reset mid-transaction:
  - Stimulus: assert reset while in WAIT_DONE.
  - Required response: the next cycle shows flashEnable=0, busy=0, both DataReady=1. A subsequent req1-only request is granted normally.
